// File: rtl/json_stream_lexer.sv
// Streaming JSON tokenizer: one registered token per structural, string or integer element,
// with a bracket stack for nesting and first-error reporting per document.
module json_stream_lexer #(
  parameter int INT_WIDTH   = 64,
  parameter int MAX_DEPTH   = 16,
  parameter int POS_WIDTH   = 32,
  parameter int DEPTH_WIDTH = $clog2(MAX_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   tok_valid,
  input  logic                   tok_ready,
  output logic [3:0]             tok_kind,
  output logic [INT_WIDTH-1:0]   tok_data,
  output logic [DEPTH_WIDTH-1:0] tok_depth,
  output logic                   tok_last,
  output logic                   err_valid,
  output logic [2:0]             err_kind,
  output logic [POS_WIDTH-1:0]   err_pos,
  output logic                   doc_done
);

  typedef enum logic [2:0] {S_IDLE, S_STRING, S_STR_ESC, S_NUMBER, S_LITERAL, S_DISCARD} state_e;

  localparam logic [3:0] K_OBJ_BEGIN = 4'd0, K_OBJ_END = 4'd1, K_ARR_BEGIN = 4'd2, K_ARR_END = 4'd3;
  localparam logic [3:0] K_COLON = 4'd4, K_COMMA = 4'd5, K_STR_BEGIN = 4'd6, K_STR_CHAR = 4'd7;
  localparam logic [3:0] K_STR_END = 4'd8, K_INT = 4'd9, K_TRUE = 4'd10;

  localparam logic [2:0] E_NONE = 3'd0, E_UNEXPECTED = 3'd1, E_LITERAL = 3'd2, E_DEPTH = 3'd3;
  localparam logic [2:0] E_MISMATCH = 3'd4, E_OVERFLOW = 3'd5, E_UNSUPPORTED = 3'd6, E_EOF = 3'd7;

  localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = DEPTH_WIDTH'(MAX_DEPTH);
  localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE = DEPTH_WIDTH'(1);
  localparam logic [POS_WIDTH-1:0]   POS_ONE   = POS_WIDTH'(1);

  state_e                 state;
  logic [DEPTH_WIDTH-1:0] depth;
  logic [MAX_DEPTH-1:0]   stack;
  logic [POS_WIDTH-1:0]   pos;
  logic [INT_WIDTH-1:0]   mag;
  logic                   neg, have_digit;
  logic [1:0]             lit_sel;
  logic [2:0]             lit_idx;

  // Byte classification and the number/literal datapath
  logic                   is_digit, num_term, num_fire, slot_free, accept, stack_top;
  logic [3:0]             digit;
  logic [INT_WIDTH+3:0]   mag_wide, mag_limit;

  // Per-byte decode result
  logic                   e_tok, e_err, push, push_obj, n_neg, n_have;
  logic [3:0]             e_kind;
  logic [INT_WIDTH-1:0]   e_data, n_mag;
  logic [DEPTH_WIDTH-1:0] e_depth, n_depth;
  logic [2:0]             e_err_kind, n_idx;
  logic [1:0]             n_sel;
  state_e                 n_state;

  function automatic logic [INT_WIDTH-1:0] sval(input logic [INT_WIDTH-1:0] m, input logic n);
    return n ? -m : m;
  endfunction

  function automatic logic [7:0] lit_char(input logic [1:0] sel, input logic [2:0] idx);
    logic [39:0] s;
    s = (sel == 2'd0) ? {"true", 8'h00} : (sel == 2'd1) ? "false" : {"null", 8'h00};
    return s[8 * (4 - int'(idx)) +: 8];
  endfunction

  assign is_digit  = (in_data >= "0") && (in_data <= "9");
  assign digit     = in_data[3:0];
  assign slot_free = !tok_valid || tok_ready;
  assign mag_wide  = ({4'b0, mag} << 3) + ({4'b0, mag} << 1) + (INT_WIDTH + 4)'(digit);
  assign mag_limit = {5'b0, {(INT_WIDTH - 1){1'b1}}} + (INT_WIDTH + 4)'(neg);

  // A terminator byte is left on the bus for one cycle while the INT token goes out.
  assign num_term = (state == S_NUMBER) && in_valid && have_digit && !is_digit &&
                    (in_data != ".") && (in_data != "e") && (in_data != "E");
  assign num_fire = num_term && slot_free;
  assign in_ready = !rst && ((state == S_DISCARD) || (slot_free && !num_term));
  assign accept   = in_valid && in_ready;

  always_comb begin
    stack_top = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++)
      if (i + 1 == int'(depth)) stack_top = stack[i];
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    e_tok = 1'b0;  e_kind = K_OBJ_BEGIN;  e_data = '0;  e_depth = depth;
    e_err = 1'b0;  e_err_kind = E_NONE;
    n_state = state;  n_depth = depth;  push = 1'b0;  push_obj = 1'b0;
    n_mag = mag;  n_neg = neg;  n_have = have_digit;  n_sel = lit_sel;  n_idx = lit_idx;
    case (state)
      S_IDLE: begin
        case (in_data)
          8'h20, 8'h09, 8'h0D, 8'h0A: ;
          "{", "[": begin
            if (depth == DEPTH_MAX) begin
              e_err = 1'b1;  e_err_kind = E_DEPTH;
            end else begin
              e_tok = 1'b1;  e_kind = (in_data == "{") ? K_OBJ_BEGIN : K_ARR_BEGIN;
              push = 1'b1;  push_obj = (in_data == "{");  n_depth = depth + DEPTH_ONE;
            end
          end
          "}", "]": begin
            if (depth == '0 || stack_top != (in_data == "}")) begin
              e_err = 1'b1;  e_err_kind = E_MISMATCH;
            end else begin
              e_tok = 1'b1;  e_kind = (in_data == "}") ? K_OBJ_END : K_ARR_END;
              n_depth = depth - DEPTH_ONE;  e_depth = depth - DEPTH_ONE;
            end
          end
          ":": begin e_tok = 1'b1;  e_kind = K_COLON; end
          ",": begin e_tok = 1'b1;  e_kind = K_COMMA; end
          "\"": begin e_tok = 1'b1;  e_kind = K_STR_BEGIN;  n_state = S_STRING; end
          "-": begin n_state = S_NUMBER;  n_neg = 1'b1;  n_have = 1'b0;  n_mag = '0; end
          "t", "f", "n": begin
            n_state = S_LITERAL;  n_idx = 3'd1;
            n_sel = (in_data == "t") ? 2'd0 : (in_data == "f") ? 2'd1 : 2'd2;
          end
          default: begin
            if (is_digit) begin
              n_state = S_NUMBER;  n_neg = 1'b0;  n_have = 1'b1;  n_mag = INT_WIDTH'(digit);
            end else begin
              e_err = 1'b1;  e_err_kind = E_UNEXPECTED;
            end
          end
        endcase
      end
      S_STRING: begin
        if (in_data == "\"") begin
          e_tok = 1'b1;  e_kind = K_STR_END;  n_state = S_IDLE;
        end else if (in_data == "\\") begin
          n_state = S_STR_ESC;
        end else if (in_data < 8'h20) begin
          e_err = 1'b1;  e_err_kind = E_UNEXPECTED;
        end else begin
          e_tok = 1'b1;  e_kind = K_STR_CHAR;  e_data = INT_WIDTH'(in_data);
        end
      end
      S_STR_ESC: begin
        e_tok = 1'b1;  e_kind = K_STR_CHAR;  n_state = S_STRING;
        case (in_data)
          "\"", "\\", "/": e_data = INT_WIDTH'(in_data);
          "b": e_data = INT_WIDTH'(8'h08);
          "f": e_data = INT_WIDTH'(8'h0C);
          "n": e_data = INT_WIDTH'(8'h0A);
          "r": e_data = INT_WIDTH'(8'h0D);
          "t": e_data = INT_WIDTH'(8'h09);
          "u": begin e_tok = 1'b0;  e_err = 1'b1;  e_err_kind = E_UNSUPPORTED; end
          default: begin e_tok = 1'b0;  e_err = 1'b1;  e_err_kind = E_UNEXPECTED; end
        endcase
      end
      S_NUMBER: begin
        if (num_term) begin
          e_tok = 1'b1;  e_kind = K_INT;  e_data = sval(mag, neg);  n_state = S_IDLE;
        end else if (is_digit) begin
          // mag == 0 with a digit already seen means a leading zero
          if (have_digit && mag == '0) begin
            e_err = 1'b1;  e_err_kind = E_UNEXPECTED;
          end else if (mag_wide > mag_limit) begin
            e_err = 1'b1;  e_err_kind = E_OVERFLOW;
          end else begin
            n_mag = mag_wide[INT_WIDTH-1:0];  n_have = 1'b1;
          end
        end else begin
          e_err = 1'b1;
          e_err_kind = (have_digit && (in_data == "." || in_data == "e" || in_data == "E"))
                       ? E_UNSUPPORTED : E_UNEXPECTED;
        end
      end
      S_LITERAL: begin
        if (in_data != lit_char(lit_sel, lit_idx)) begin
          e_err = 1'b1;  e_err_kind = E_LITERAL;
        end else if (lit_idx == ((lit_sel == 2'd1) ? 3'd4 : 3'd3)) begin
          e_tok = 1'b1;  e_kind = K_TRUE + {2'b0, lit_sel};  n_state = S_IDLE;
        end else begin
          n_idx = lit_idx + 3'd1;
        end
      end
      default: ;
    endcase

    // The last byte of a document must leave the lexer idle at depth 0.
    if (state != S_DISCARD && accept && in_last && !e_err) begin
      if (n_state == S_NUMBER) begin
        if (n_have) begin
          e_tok = 1'b1;  e_kind = K_INT;  e_data = sval(n_mag, n_neg);  n_state = S_IDLE;
        end else begin
          e_err = 1'b1;  e_err_kind = E_UNEXPECTED;
        end
      end
      if (!e_err && (n_state != S_IDLE || n_depth != '0)) begin
        e_tok = 1'b0;  e_err = 1'b1;  e_err_kind = E_EOF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the bracket stack is reset along with the control state; it is small flop storage, not RAM.
      state <= S_IDLE;  depth <= '0;  stack <= '0;  pos <= '0;
      mag <= '0;  neg <= 1'b0;  have_digit <= 1'b0;  lit_sel <= 2'd0;  lit_idx <= 3'd0;
      tok_valid <= 1'b0;  tok_kind <= 4'd0;  tok_data <= '0;  tok_depth <= '0;  tok_last <= 1'b0;
      err_valid <= 1'b0;  err_kind <= 3'd0;  err_pos <= '0;  doc_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in this block override earlier defaults.
      doc_done <= 1'b0;
      if (tok_valid && tok_ready) tok_valid <= 1'b0;
      if (state != S_DISCARD) err_valid <= 1'b0;

      if (state == S_DISCARD) begin
        if (accept) begin
          pos <= pos + POS_ONE;
          if (in_last) begin
            state <= S_IDLE;  err_valid <= 1'b0;  depth <= '0;  stack <= '0;  pos <= '0;
          end
        end
      end else if (accept || num_fire) begin
        if (e_err) begin
          err_valid <= 1'b1;  err_kind <= e_err_kind;  err_pos <= pos;
          state <= in_last ? S_IDLE : S_DISCARD;
        end else begin
          state <= n_state;  depth <= n_depth;
          mag <= n_mag;  neg <= n_neg;  have_digit <= n_have;  lit_sel <= n_sel;  lit_idx <= n_idx;
          if (push)
            for (int i = 0; i < MAX_DEPTH; i++)
              if (i == int'(depth)) stack[i] <= push_obj;
          if (e_tok) begin
            tok_valid <= 1'b1;  tok_kind <= e_kind;  tok_data <= e_data;
            tok_depth <= e_depth;  tok_last <= accept && in_last;
          end
          if (accept && in_last) doc_done <= 1'b1;
        end
        if (accept) pos <= pos + POS_ONE;
        if (accept && in_last) begin
          depth <= '0;  stack <= '0;  pos <= '0;
        end
      end
    end
  end

endmodule
